config_chain_loader: RTL and testbench
======================================

// Module: config_chain_loader
// PURPOSE
//  Programming-side front end for the fabric configuration chain. Accepts the
//  bitstream as bytes over a valid/ready stream, serialises it MSB-first into
//  the head of the ccff scan chain whose bits drive the mux-tree and LUT sram
//  selects, and counts exactly CHAIN_LEN shifts. It then checks an XOR parity
//  trailer byte and flags done or error. Sits between the tile's programming
//  interface and the ccff chain.
// PARAMETERS
//  CHAIN_LEN  12                          total config bits in chain (>=1)
//  CNT_W      $clog2(CHAIN_LEN+1)         width of shift counter
// PORTS
//  prog_clk      in   1      programming clock, all state on rising edge
//  prog_reset_n  in   1      asynchronous, active-low reset
//  start         in   1      1-cycle pulse: begin a load
//  abort         in   1      1-cycle pulse: cancel the current load
//  s_data        in   8      bitstream byte, MSB shifted first
//  s_valid       in   1      s_data valid
//  s_ready       out  1      byte accepted when s_valid & s_ready
//  ccff_head     out  1      serial data into chain head
//  ccff_shift_en out  1      chain shift enable; chain samples ccff_head on this cycle
//  busy          out  1      high in LOAD and CHECK
//  cfg_done      out  1      sticky: chain loaded and parity matched
//  cfg_error     out  1      sticky: parity mismatch
// BEHAVIOUR
//  Reset: prog_reset_n is asynchronous and active-low. All outputs go to 0,
//   state goes to IDLE, and the counter and serialiser are cleared.
//   Chain contents after a reset mid-load are undefined and are not repaired.
//  FSM states:
//   IDLE  -> LOAD on start. cfg_done and cfg_error are cleared and the
//            parity accumulator is zeroed.
//   LOAD  -> CHECK when the CHAIN_LEN-th shift cycle completes.
//   CHECK -> DONE when trailer == acc, else ERROR.
//   DONE  -> LOAD on start.
//   ERROR -> LOAD on start.
//   abort in LOAD or CHECK -> IDLE on the next edge: shift_en and busy go 0,
//    the serialiser is flushed, and the flags stay 0.
//   start while busy is ignored. abort in IDLE, DONE or ERROR is ignored.
//   If start and abort are high in the same cycle, abort wins.
//  Serialiser: an 8-bit shift register plus a remaining-bit count (0..8).
//   A byte is accepted in cycle N. Its bit7 appears on ccff_head with
//    ccff_shift_en=1 in cycle N+1, then bit6 in N+2, and so on.
//   One bit per cycle. ccff_shift_en=1 only while a valid chain bit is presented.
//   s_ready=1 in LOAD when remaining<=1 and the bits still owed exceed those
//    already buffered. This lets a held s_valid give gap-free shifting at
//    8 bits per 8 cycles.
//   Last byte: only the top (CHAIN_LEN-8*(bytes-1)) bits are shifted. The
//    unused low bits are dropped without asserting shift_en.
//   Shift counter: CNT_W bits. Increments on each shift_en cycle and never
//    exceeds CHAIN_LEN. No further data bytes are accepted after the last one.
//  Parity: acc ^= s_data over every accepted data byte, whole byte including
//   the dropped pad bits.
//   In CHECK, s_ready=1. The accepted byte is the trailer and is compared
//    with acc.
//   On the edge that accepts the trailer: cfg_done or cfg_error is set and
//    busy drops.
//   CHECK has no timeout. It waits for the trailer or an abort.
//  ccff_head=0 whenever ccff_shift_en=0.
// TESTING
//  1 CHAIN_LEN=12; start; bytes 0xA5, 0x30, trailer 0x95 ->
//    12 shift_en cycles with head 1,0,1,0,0,1,0,1,0,0,1,1.
//    cfg_done=1 and busy=0 on the cycle after the trailer handshake.
//  2 Same data, trailer 0x00 -> cfg_error=1, cfg_done=0, exactly 12 shift_en
//    cycles. A new start then clears cfg_error.
//  3 s_valid held high throughout -> shift_en high for 12 consecutive cycles,
//    s_ready pulses exactly twice during LOAD.
//  4 s_valid low for 5 cycles between bytes -> shift_en low during the gap,
//    the 12-bit sequence is unchanged and cfg_done=1.
//  5 abort after 5 shifts -> shift_en, busy and flags are 0 next cycle.
//    prog_reset_n pulsed low mid-byte -> all outputs 0 immediately.
//    In both cases a following full load gives cfg_done=1.
//  6 start pulsed during LOAD, and start+abort together -> the load is
//    unaffected in the first case; abort wins in the second (IDLE).

Source files
------------

// File: rtl/config_chain_loader.sv
// Byte-stream front end for the fabric ccff configuration chain.
// Serialises bytes MSB-first into the chain head and checks an XOR trailer.
module config_chain_loader #(
  parameter int CHAIN_LEN = 12,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       prog_clk,
  input  logic       prog_reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic in_load, in_check, shift, hs, last;
  logic [3:0] rem_new;
  int owed, left;

  always_comb begin
    in_load  = (state_q == S_LOAD);
    in_check = (state_q == S_CHECK);
    owed     = CHAIN_LEN - int'(cnt_q);
    // bits not yet committed to the serialiser
    left     = owed - int'(rem_q);
    rem_new  = (left >= 8) ? 4'd8 : 4'(left);
    shift    = in_load && (rem_q != 4'd0);
    last     = shift && (cnt_q == CNT_W'(CHAIN_LEN - 1));
    s_ready  = in_check ||
               (in_load && (rem_q <= 4'd1) && (left > 0));
    hs       = s_valid && s_ready;

    state_d = state_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = done_q;
    err_d   = err_q;

    if (abort && (in_load || in_check)) begin
      state_d = S_IDLE;
      sreg_d  = 8'd0;
      rem_d   = 4'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (shift) begin
            sreg_d = {sreg_q[6:0], 1'b0};
            rem_d  = rem_q - 4'd1;
            cnt_d  = cnt_q + CNT_W'(1);
          end
          if (hs) begin
            sreg_d = s_data;
            rem_d  = rem_new;
            acc_d  = acc_q ^ s_data;
          end
          if (last) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (hs) begin
            done_d  = (s_data == acc_q);
            err_d   = (s_data != acc_q);
            state_d = (s_data == acc_q) ? S_DONE : S_ERR;
          end
        end
        default: begin
          if (start) begin
            state_d = S_LOAD;
            sreg_d  = 8'd0;
            rem_d   = 4'd0;
            cnt_d   = '0;
            acc_d   = 8'd0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= S_IDLE;
      sreg_q  <= 8'd0;
      rem_q   <= 4'd0;
      cnt_q   <= '0;
      acc_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ccff_shift_en = shift;
  assign ccff_head     = shift & sreg_q[7];
  assign busy          = in_load || in_check;
  assign cfg_done      = done_q;
  assign cfg_error     = err_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with CHAIN_LEN=12.
// Tracks the serial chain stream at each falling edge.
module tb_config_chain_loader;

  logic       prog_clk = 1'b0;
  logic       prog_reset_n;
  logic       start, abort;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready, ccff_head, ccff_shift_en;
  logic       busy, cfg_done, cfg_error;

  int npass = 0;
  int ntot  = 0;
  int nshift, run, maxrun, rdy;
  logic [11:0] seq;

  config_chain_loader #(.CHAIN_LEN(12)) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .abort         (abort),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .busy          (busy),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge prog_clk) begin
    if (busy && s_ready && nshift < 12) rdy++;
    if (ccff_shift_en) begin
      seq = {seq[10:0], ccff_head};
      nshift++;
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
      if (prog_reset_n) chk("head_idle", 32'(ccff_head), 0);
    end
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic clr();
    nshift = 0;
    seq = '0;
    run = 0;
    maxrun = 0;
    rdy = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bit ok;
    ok = 0;
    s_data = b;
    s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge prog_clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("push_timeout", 0, 1);
    tick();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic full_load(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] t);
    clr();
    pulse_start();
    push(b0);
    push(b1);
    push(t);
    s_valid = 1'b0;
  endtask

  initial begin
    clr();
    prog_reset_n = 1'b0;
    start = 0;
    abort = 0;
    s_data = 0;
    s_valid = 0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(cfg_done), 0);
    chk("rst_err", 32'(cfg_error), 0);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_shift", 32'(ccff_shift_en), 0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    tick();

    // 1: good load
    full_load(8'hA5, 8'h30, 8'h95);
    chk("t1_done", 32'(cfg_done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_err", 32'(cfg_error), 0);
    chk("t1_nshift", nshift, 12);
    chk("t1_seq", 32'(seq), 32'hA53);

    // 2: bad trailer, then restart clears the error
    full_load(8'hA5, 8'h30, 8'h00);
    chk("t2_err", 32'(cfg_error), 1);
    chk("t2_done", 32'(cfg_done), 0);
    chk("t2_nshift", nshift, 12);
    clr();
    pulse_start();
    chk("t2_err_clr", 32'(cfg_error), 0);
    chk("t2_busy", 32'(busy), 1);

    // 3: valid held high, continuing the load just started
    push(8'hA5);
    push(8'h30);
    push(8'h95);
    s_valid = 1'b0;
    chk("t3_run", maxrun, 12);
    chk("t3_rdy", rdy, 2);
    chk("t3_seq", 32'(seq), 32'hA53);
    chk("t3_done", 32'(cfg_done), 1);

    // 4: five-cycle gap between bytes
    clr();
    pulse_start();
    push(8'hA5);
    idle(8);
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      chk("t4_gap_shift", 32'(ccff_shift_en), 0);
      tick();
    end
    push(8'h30);
    push(8'h95);
    s_valid = 1'b0;
    chk("t4_seq", 32'(seq), 32'hA53);
    chk("t4_nshift", nshift, 12);
    chk("t4_done", 32'(cfg_done), 1);

    // 5a: abort after five shifts
    clr();
    pulse_start();
    push(8'hA5);
    idle(5);
    chk("t5_pre_nshift", nshift, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_ab_shift", 32'(ccff_shift_en), 0);
    chk("t5_ab_busy", 32'(busy), 0);
    chk("t5_ab_done", 32'(cfg_done), 0);
    chk("t5_ab_err", 32'(cfg_error), 0);
    full_load(8'hA5, 8'h30, 8'h95);
    chk("t5_ab_reload", 32'(cfg_done), 1);
    chk("t5_ab_seq", 32'(seq), 32'hA53);

    // 5b: asynchronous reset mid-byte
    clr();
    pulse_start();
    push(8'hA5);
    idle(3);
    #2 prog_reset_n = 1'b0;
    #1;
    chk("t5_rst_shift", 32'(ccff_shift_en), 0);
    chk("t5_rst_head", 32'(ccff_head), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(s_ready), 0);
    chk("t5_rst_done", 32'(cfg_done), 0);
    chk("t5_rst_err", 32'(cfg_error), 0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    tick();
    full_load(8'hA5, 8'h30, 8'h95);
    chk("t5_rst_reload", 32'(cfg_done), 1);
    chk("t5_rst_seq", 32'(seq), 32'hA53);

    // 6a: start while loading is ignored
    clr();
    pulse_start();
    push(8'hA5);
    idle(2);
    pulse_start();
    push(8'h30);
    push(8'h95);
    s_valid = 1'b0;
    chk("t6_nshift", nshift, 12);
    chk("t6_seq", 32'(seq), 32'hA53);
    chk("t6_done", 32'(cfg_done), 1);

    // 6b: start together with abort -> abort wins
    clr();
    pulse_start();
    push(8'hA5);
    s_valid = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t6_sa_busy", 32'(busy), 0);
    chk("t6_sa_shift", 32'(ccff_shift_en), 0);
    tick();
    chk("t6_sa_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
